// File: rtl/fifo_block_packer.sv
// Packs show-ahead FIFO bytes MSB-first into fixed-width blocks for the RSA core.
// Partial blocks are closed (zero-padded) on flush or after an idle timeout.
module fifo_block_packer #(
  parameter int BLOCK_BYTES  = 4,
  parameter int IDLE_TIMEOUT = 1000,
  parameter int CNT_W        = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fifo_empty,
  input  logic [7:0]               fifo_data,
  output logic                     fifo_rd_en,
  input  logic                     flush,
  output logic [BLOCK_BYTES*8-1:0] blk_data,
  output logic [CNT_W-1:0]         blk_nbytes,
  output logic                     blk_valid,
  input  logic                     blk_ready,
  output logic                     blk_partial
);

  localparam int BW   = BLOCK_BYTES * 8;
  localparam int BC_W = $clog2(BLOCK_BYTES + 1);
  localparam int IC_W = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
  localparam logic [BC_W-1:0] BC_FULL = BC_W'(BLOCK_BYTES);
  localparam logic [IC_W-1:0] IC_LAST = IC_W'((IDLE_TIMEOUT > 0) ? IDLE_TIMEOUT - 1 : 0);

  typedef enum logic {
    COLLECT = 1'b0,
    PRESENT = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [BC_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [IC_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic [BW-1:0]     shreg_q, shreg_d;
  logic [BW-1:0]     blk_data_q, blk_data_d;
  logic [CNT_W-1:0]  blk_nbytes_q, blk_nbytes_d;
  logic              blk_valid_q, blk_valid_d;
  logic              blk_partial_q, blk_partial_d;
  logic              timeout_s;

  // Pop is combinational so the FIFO head advances on the capturing edge.
  assign fifo_rd_en  = (state_q == COLLECT) && !fifo_empty && !rst;
  assign blk_data    = blk_data_q;
  assign blk_nbytes  = blk_nbytes_q;
  assign blk_valid   = blk_valid_q;
  assign blk_partial = blk_partial_q;

  always_comb begin
    state_d       = state_q;
    byte_cnt_d    = byte_cnt_q;
    idle_cnt_d    = idle_cnt_q;
    shreg_d       = shreg_q;
    blk_data_d    = blk_data_q;
    blk_nbytes_d  = blk_nbytes_q;
    blk_valid_d   = blk_valid_q;
    blk_partial_d = blk_partial_q;
    timeout_s     = 1'b0;
    case (state_q)
      COLLECT: begin
        if (fifo_rd_en) begin
          for (int i = 0; i < BLOCK_BYTES; i++) begin
            if (BC_W'(i) == byte_cnt_q) begin
              shreg_d[(BLOCK_BYTES-1-i)*8 +: 8] = fifo_data;
            end else begin
              shreg_d[(BLOCK_BYTES-1-i)*8 +: 8] = shreg_q[(BLOCK_BYTES-1-i)*8 +: 8];
            end
          end
          byte_cnt_d = byte_cnt_q + 1'b1;
        end else begin
          byte_cnt_d = byte_cnt_q;
        end
        // With the timeout disabled the idle counter stays parked at zero.
        if (fifo_rd_en || (byte_cnt_q == '0) || (IDLE_TIMEOUT == 0)) begin
          idle_cnt_d = '0;
        end else begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
        timeout_s = (IDLE_TIMEOUT != 0) && !fifo_rd_en &&
                    (byte_cnt_q != '0) && (idle_cnt_q == IC_LAST);
        if ((byte_cnt_d == BC_FULL) || ((flush || timeout_s) && (byte_cnt_d != '0))) begin
          blk_data_d    = shreg_d;
          blk_nbytes_d  = CNT_W'(byte_cnt_d);
          blk_partial_d = (byte_cnt_d != BC_FULL);
          blk_valid_d   = 1'b1;
          idle_cnt_d    = '0;
          state_d       = PRESENT;
        end else begin
          state_d = COLLECT;
        end
      end
      PRESENT: begin
        if (blk_valid_q && blk_ready) begin
          blk_valid_d = 1'b0;
          byte_cnt_d  = '0;
          idle_cnt_d  = '0;
          shreg_d     = '0;
          state_d     = COLLECT;
        end else begin
          state_d = PRESENT;
        end
      end
      default: begin
        state_d = COLLECT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= COLLECT;
      byte_cnt_q    <= '0;
      idle_cnt_q    <= '0;
      shreg_q       <= '0;
      blk_data_q    <= '0;
      blk_nbytes_q  <= '0;
      blk_valid_q   <= 1'b0;
      blk_partial_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      byte_cnt_q    <= byte_cnt_d;
      idle_cnt_q    <= idle_cnt_d;
      shreg_q       <= shreg_d;
      blk_data_q    <= blk_data_d;
      blk_nbytes_q  <= blk_nbytes_d;
      blk_valid_q   <= blk_valid_d;
      blk_partial_q <= blk_partial_d;
    end
  end

endmodule

// File: tb/tb_fifo_block_packer.sv
// Directed bench for fifo_block_packer with a behavioural show-ahead FIFO.
module tb_fifo_block_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        fifo_empty;
  logic [7:0]  fifo_data;
  logic        fifo_rd_en;
  logic        flush;
  logic [31:0] blk_data;
  logic [7:0]  blk_nbytes;
  logic        blk_valid;
  logic        blk_ready;
  logic        blk_partial;

  logic        fifo_rd_en_0;
  logic [31:0] blk_data_0;
  logic [7:0]  blk_nbytes_0;
  logic        blk_valid_0;
  logic        blk_partial_0;

  logic [7:0] fmem [64];
  int rd_ptr = 0;
  int wr_ptr = 0;
  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  assign fifo_empty = (rd_ptr == wr_ptr);
  assign fifo_data  = fmem[rd_ptr % 64];

  always @(posedge clk) begin
    if (fifo_rd_en && !fifo_empty) rd_ptr <= rd_ptr + 1;
  end

  fifo_block_packer #(.BLOCK_BYTES(4), .IDLE_TIMEOUT(16), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_rd_en(fifo_rd_en), .flush(flush), .blk_data(blk_data),
    .blk_nbytes(blk_nbytes), .blk_valid(blk_valid), .blk_ready(blk_ready),
    .blk_partial(blk_partial)
  );

  fifo_block_packer #(.BLOCK_BYTES(4), .IDLE_TIMEOUT(0), .CNT_W(8)) u_dut0 (
    .clk(clk), .rst(rst), .fifo_empty(1'b1), .fifo_data(8'h00),
    .fifo_rd_en(fifo_rd_en_0), .flush(1'b0), .blk_data(blk_data_0),
    .blk_nbytes(blk_nbytes_0), .blk_valid(blk_valid_0), .blk_ready(1'b1),
    .blk_partial(blk_partial_0)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    fmem[wr_ptr % 64] = b;
    wr_ptr++;
  endtask

  task automatic wait_valid(input int budget, output int n);
    n = 0;
    while (!blk_valid && n < budget) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; blk_ready = 1'b0;
    step(); step();
    checks++; if (blk_valid !== 1'b0) $display("FAIL reset_valid got %0b want 0", blk_valid); else passes++;
    checks++; if (blk_data !== 32'h0) $display("FAIL reset_data got %h want 0", blk_data); else passes++;
    checks++; if (blk_nbytes !== 8'd0) $display("FAIL reset_nbytes got %0d want 0", blk_nbytes); else passes++;
    checks++; if (blk_partial !== 1'b0) $display("FAIL reset_partial got %0b want 0", blk_partial); else passes++;
    checks++; if (fifo_rd_en !== 1'b0) $display("FAIL reset_rd_en got %0b want 0", fifo_rd_en); else passes++;
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_block();
    int n;
    int p0;
    blk_ready = 1'b1;
    p0 = rd_ptr;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    wait_valid(20, n);
    checks++; if (n !== 4) $display("FAIL single_latency got %0d want 4", n); else passes++;
    checks++; if (blk_data !== 32'h11223344) $display("FAIL single_data got %h want 11223344", blk_data); else passes++;
    checks++; if (blk_nbytes !== 8'd4) $display("FAIL single_nbytes got %0d want 4", blk_nbytes); else passes++;
    checks++; if (blk_partial !== 1'b0) $display("FAIL single_partial got %0b want 0", blk_partial); else passes++;
    checks++; if (rd_ptr - p0 !== 4) $display("FAIL single_pops got %0d want 4", rd_ptr - p0); else passes++;
    step();
    checks++; if (blk_valid !== 1'b0) $display("FAIL single_drop got %0b want 0", blk_valid); else passes++;
  endtask

  task automatic test_backpressure();
    int n;
    int bad;
    blk_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push(8'(i));
    wait_valid(20, n);
    checks++; if (n !== 4) $display("FAIL bp_latency got %0d want 4", n); else passes++;
    checks++; if (blk_data !== 32'h01020304) $display("FAIL bp_first_data got %h want 01020304", blk_data); else passes++;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (blk_valid !== 1'b1 || blk_data !== 32'h01020304 || fifo_rd_en !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) $display("FAIL bp_hold bad_cycles got %0d want 0", bad); else passes++;
    blk_ready = 1'b1;
    step();
    checks++; if (blk_valid !== 1'b0) $display("FAIL bp_accept got %0b want 0", blk_valid); else passes++;
    wait_valid(20, n);
    checks++; if (n !== 4) $display("FAIL bp_second_latency got %0d want 4", n); else passes++;
    checks++; if (blk_data !== 32'h05060708) $display("FAIL bp_second_data got %h want 05060708", blk_data); else passes++;
    checks++; if (blk_nbytes !== 8'd4) $display("FAIL bp_second_nbytes got %0d want 4", blk_nbytes); else passes++;
    checks++; if (wr_ptr - rd_ptr !== 0) $display("FAIL bp_fifo_count got %0d want 0", wr_ptr - rd_ptr); else passes++;
    step();
  endtask

  task automatic test_timeout();
    int n;
    blk_ready = 1'b1;
    push(8'hAB); push(8'hCD);
    wait_valid(40, n);
    // 2 pop edges plus 16 idle edges
    checks++; if (n !== 18) $display("FAIL to_latency got %0d want 18", n); else passes++;
    checks++; if (blk_data !== 32'hABCD0000) $display("FAIL to_data got %h want ABCD0000", blk_data); else passes++;
    checks++; if (blk_nbytes !== 8'd2) $display("FAIL to_nbytes got %0d want 2", blk_nbytes); else passes++;
    checks++; if (blk_partial !== 1'b1) $display("FAIL to_partial got %0b want 1", blk_partial); else passes++;
    step();
    checks++; if (blk_valid !== 1'b0) $display("FAIL to_drop got %0b want 0", blk_valid); else passes++;
  endtask

  task automatic test_flush();
    int bad;
    flush = 1'b1;
    step();
    flush = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (blk_valid !== 1'b0) bad++;
      step();
    end
    checks++; if (bad !== 0) $display("FAIL flush_empty bad_cycles got %0d want 0", bad); else passes++;
    push(8'h55); push(8'h66);
    step(); step();
    push(8'h77);
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++; if (blk_valid !== 1'b1) $display("FAIL flush_valid got %0b want 1", blk_valid); else passes++;
    checks++; if (blk_data !== 32'h55667700) $display("FAIL flush_data got %h want 55667700", blk_data); else passes++;
    checks++; if (blk_nbytes !== 8'd3) $display("FAIL flush_nbytes got %0d want 3", blk_nbytes); else passes++;
    checks++; if (blk_partial !== 1'b1) $display("FAIL flush_partial got %0b want 1", blk_partial); else passes++;
    step();
  endtask

  task automatic test_reset_mid();
    int n;
    push(8'hC1); push(8'hC2);
    step(); step();
    push(8'hD1); push(8'hD2); push(8'hD3); push(8'hD4);
    rst = 1'b1;
    #1;
    checks++; if (blk_data !== 32'h0) $display("FAIL rmid_data got %h want 0", blk_data); else passes++;
    checks++; if (blk_nbytes !== 8'd0) $display("FAIL rmid_nbytes got %0d want 0", blk_nbytes); else passes++;
    checks++; if (blk_partial !== 1'b0) $display("FAIL rmid_partial got %0b want 0", blk_partial); else passes++;
    checks++; if (fifo_rd_en !== 1'b0) $display("FAIL rmid_rd_en got %0b want 0", fifo_rd_en); else passes++;
    step(); step();
    checks++; if (wr_ptr - rd_ptr !== 4) $display("FAIL rmid_no_pop got %0d want 4", wr_ptr - rd_ptr); else passes++;
    rst = 1'b0;
    wait_valid(20, n);
    checks++; if (n !== 4) $display("FAIL rmid_latency got %0d want 4", n); else passes++;
    checks++; if (blk_data !== 32'hD1D2D3D4) $display("FAIL rmid_block got %h want D1D2D3D4", blk_data); else passes++;
    checks++; if (blk_partial !== 1'b0) $display("FAIL rmid_block_partial got %0b want 0", blk_partial); else passes++;
    step();
  endtask

  task automatic test_no_timeout();
    int bad;
    bad = 0;
    for (int i = 0; i < 5000; i++) begin
      step();
      if (fifo_rd_en_0 !== 1'b0 || blk_valid_0 !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) $display("FAIL notimeout bad_cycles got %0d want 0", bad); else passes++;
  endtask

  initial begin
    test_reset();
    test_single_block();
    test_backpressure();
    test_timeout();
    test_flush();
    test_reset_mid();
    test_no_timeout();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
